// File: rtl/matmul_result_streamer_if.sv
// Handshake bundle between the matmul result producer, the streamer and the downstream consumer.
// The master modport is the streamer's view; the slave modport drives captures and consumes the stream.
interface matmul_result_streamer_if #(
  parameter int BIT_PREC = 8,
  parameter int N        = 4
);
  localparam int RW = 2*BIT_PREC + 1;

  logic                 in_valid;
  logic signed [RW-1:0] C [N][N];
  logic                 in_ready;
  logic signed [RW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  modport master (
    input  in_valid, C, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport slave (
    output in_valid, C, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/matmul_result_streamer.sv
// Captures 4x4 result matrices into a two-slot ping-pong buffer and streams them row-major.
// First element is presented the cycle after capture; out_ready stalls hold data; full buffer drops with sticky overflow.
module matmul_result_streamer #(
  parameter int BIT_PREC      = 8,
  parameter int N             = 4,
  parameter int CAPTURE_DELAY = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  matmul_result_streamer_if.master      bus,
  input  logic                          clr_err,
  output logic                          overflow,
  output logic [15:0]                   frames_out
);
  localparam int RW = 2*BIT_PREC + 1;
  localparam int NE = N*N;
  localparam int IW = $clog2(NE);

  typedef enum logic {EMPTY, STREAM} state_e;

  state_e               state_q, state_d;
  logic [1:0]           count_q, count_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 pend_q;
  logic                 overflow_q, overflow_d;
  logic [15:0]          frames_q, frames_d;
  logic signed [RW-1:0] slot_q [2][NE];

  logic cap_evt, cap_ok, xfer, final_pop;

  // With CAPTURE_DELAY=1 the strobe only arms a flag; C is sampled one edge later.
  assign cap_evt   = (CAPTURE_DELAY == 0) ? bus.in_valid : pend_q;
  assign xfer      = bus.out_valid && bus.out_ready;
  assign final_pop = xfer && (idx_q == IW'(NE-1));
  assign cap_ok    = cap_evt && ((count_q < 2'd2) || final_pop);

  assign bus.in_ready  = (count_q < 2'd2);
  assign bus.out_valid = (state_q == STREAM);
  assign bus.out_last  = (state_q == STREAM) && (idx_q == IW'(NE-1));
  assign bus.out_data  = (state_q == STREAM) ? slot_q[rd_ptr_q][idx_q] : '0;
  assign overflow      = overflow_q;
  assign frames_out    = frames_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    frames_d   = frames_q;

    if (clr_err) overflow_d = 1'b0;
    if (cap_evt && !cap_ok) overflow_d = 1'b1;

    if (cap_ok) wr_ptr_d = ~wr_ptr_q;

    if (xfer) begin
      if (final_pop) begin
        idx_d    = '0;
        rd_ptr_d = ~rd_ptr_q;
        frames_d = frames_q + 16'd1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end

    count_d = count_q + {1'b0, cap_ok} - {1'b0, final_pop};

    case (state_q)
      EMPTY:   if (cap_ok) state_d = STREAM;
      STREAM:  if (final_pop && (count_q == 2'd1) && !cap_ok) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= EMPTY;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      overflow_q <= 1'b0;
      frames_q   <= 16'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      idx_q      <= idx_d;
      pend_q     <= (CAPTURE_DELAY == 1) ? bus.in_valid : 1'b0;
      overflow_q <= overflow_d;
      frames_q   <= frames_d;
    end
  end

  // Payload storage carries no reset; out_data is masked while EMPTY.
  always_ff @(posedge clk) begin
    if (cap_ok) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          slot_q[wr_ptr_q][i*N+j] <= bus.C[i][j];
        end
      end
    end
  end
endmodule

// File: tb/tb_matmul_result_streamer.sv
// Scoreboard bench for matmul_result_streamer: stimulus pushes expected elements, a negedge monitor pops on transfers.
module tb_matmul_result_streamer;
  localparam int BP = 8;
  localparam int N  = 4;
  localparam int RW = 2*BP + 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clr_err = 1'b0;
  logic        overflow;
  logic [15:0] frames_out;

  matmul_result_streamer_if #(.BIT_PREC(BP), .N(N)) bus();

  matmul_result_streamer #(.BIT_PREC(BP), .N(N), .CAPTURE_DELAY(1)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .clr_err    (clr_err),
    .overflow   (overflow),
    .frames_out (frames_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [RW:0] exp_q [$];
  logic signed [RW-1:0] m [16];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops one expected {last,data} per transfer; also checks out_valid never drops mid-stall.
  logic prev_stall = 1'b0;
  bit   gap_armed  = 1'b0;
  int   gap_n      = 0;
  int   last_cyc   = 0;
  always @(negedge clk) begin
    logic [RW:0] e;
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_cmp++;
        if (!bus.out_valid) begin
          n_err++;
          $display("FAIL valid_hold: out_valid got 0, want 1 after stall");
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_xfer: got data %0d last %0d, want no transfer",
                   $signed(bus.out_data), bus.out_last);
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_last, bus.out_data} !== e) begin
            n_err++;
            $display("FAIL stream: got data %0d last %0d, want data %0d last %0d",
                     $signed(bus.out_data), bus.out_last, $signed(e[RW-1:0]), e[RW]);
          end
        end
        if (gap_armed && cyc != last_cyc + 1) gap_n++;
        gap_armed = 1'b1;
        last_cyc  = cyc;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  task automatic load_c(input bit push);
    for (int k = 0; k < 16; k++) begin
      bus.C[k/4][k%4] = m[k];
      if (push) exp_q.push_back({(k == 15), m[k]});
    end
  endtask

  // Strobe in_valid for one cycle and hold C through the delayed sampling edge.
  task automatic capture(input bit push);
    load_c(push);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic drain(input string nm, input int bound);
    int k = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && k < bound) begin
      tick();
      k++;
    end
    n_cmp++;
    if (k >= bound) begin
      n_err++;
      $display("FAIL %s: drain timeout, got %0d pending, want 0", nm, exp_q.size());
    end
  endtask

  initial begin
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 16; k++) bus.C[k/4][k%4] = '0;

    // Reset values
    #2;
    chk("rst_in_ready",  32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_last",  32'(bus.out_last), 0);
    chk("rst_out_data",  32'(bus.out_data), 0);
    chk("rst_overflow",  32'(overflow), 0);
    chk("rst_frames",    32'(frames_out), 0);
    tick(); tick();
    rstn = 1'b1;
    tick();

    // 1: single matrix, -8..7, latency 2 cycles from strobe
    bus.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) m[k] = RW'(k - 8);
    load_c(1'b1);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("t1_valid_c1", 32'(bus.out_valid), 0);
    tick();
    chk("t1_valid_c2", 32'(bus.out_valid), 1);
    drain("t1_drain", 100);
    chk("t1_frames", 32'(frames_out), 1);

    // 2: backpressure pattern 1,0,0,1
    bus.out_ready = 1'b0;
    capture(1'b1);
    begin
      int k = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && k < 200) begin
        bus.out_ready = pat[k % 4];
        tick();
        k++;
      end
      chk("t2_no_timeout", 32'(k < 200), 1);
    end
    chk("t2_frames", 32'(frames_out), 2);

    // 3: ping-pong, max positive then max negative, strobes 3 cycles apart
    bus.out_ready = 1'b1;
    gap_armed = 1'b0;
    gap_n     = 0;
    for (int k = 0; k < 16; k++) m[k] = 17'sd65535;
    capture(1'b1);
    tick();
    for (int k = 0; k < 16; k++) m[k] = -17'sd65536;
    capture(1'b1);
    drain("t3_drain", 100);
    chk("t3_bubbles", 32'(gap_n), 0);
    chk("t3_frames", 32'(frames_out), 4);

    // 4: overflow with three captures while stalled
    bus.out_ready = 1'b0;
    for (int k = 0; k < 16; k++) m[k] = RW'(100 + k);
    capture(1'b1);
    for (int k = 0; k < 16; k++) m[k] = RW'(-(k + 1) * 1000);
    capture(1'b1);
    chk("t4_in_ready_full", 32'(bus.in_ready), 0);
    chk("t4_no_ovf_yet", 32'(overflow), 0);
    for (int k = 0; k < 16; k++) m[k] = RW'(7777);
    capture(1'b0);
    chk("t4_overflow", 32'(overflow), 1);
    chk("t4_in_ready", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    drain("t4_drain", 100);
    chk("t4_frames", 32'(frames_out), 6);
    chk("t4_ovf_sticky", 32'(overflow), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t4_clr_err", 32'(overflow), 0);
    chk("t4_in_ready_empty", 32'(bus.in_ready), 1);

    // 5: capture lands on the final pop of slot[rd_ptr] with both slots full
    bus.out_ready = 1'b0;
    for (int k = 0; k < 16; k++) m[k] = RW'(k * 3);
    capture(1'b1);
    for (int k = 0; k < 16; k++) m[k] = RW'(-k * 5);
    capture(1'b1);
    bus.out_ready = 1'b1;
    repeat (15) tick();
    bus.out_ready = 1'b0;
    chk("t5_last_at_15", 32'(bus.out_last), 1);
    for (int k = 0; k < 16; k++) m[k] = RW'(2000 + k);
    load_c(1'b1);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("t5_no_overflow", 32'(overflow), 0);
    chk("t5_in_ready", 32'(bus.in_ready), 0);
    drain("t5_drain", 100);
    chk("t5_frames", 32'(frames_out), 9);

    // 6: reset at idx=7 mid-stream
    bus.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) m[k] = RW'(-300 + k);
    capture(1'b1);
    repeat (7) tick();
    rstn = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_valid",    32'(bus.out_valid), 0);
    chk("t6_data",     32'(bus.out_data), 0);
    chk("t6_last",     32'(bus.out_last), 0);
    chk("t6_in_ready", 32'(bus.in_ready), 1);
    chk("t6_frames",   32'(frames_out), 0);
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    chk("t6_idle", 32'(bus.out_valid), 0);
    for (int k = 0; k < 16; k++) m[k] = RW'(k * 11 - 60);
    capture(1'b1);
    drain("t6_drain", 100);
    chk("t6_frames_after", 32'(frames_out), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
